// File: rtl/fork_join_pkg.sv
// -----------------------------------------------------------------------------
// fork_join_pkg
// Shared definitions for the fork/join scheduler:
//   - join_mode_e : how the parent thread is released after a fork
//   - fsm_state_e : scheduler sequencing states
//   - DEF_NUM_TASKS / DEF_CNT_W : default child count and duration width
//   - parent_release() : decides whether the parent may continue this cycle
// -----------------------------------------------------------------------------
package fork_join_pkg;

  localparam int DEF_NUM_TASKS = 4;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    MODE_JOIN      = 2'b00,
    MODE_JOIN_ANY  = 2'b01,
    MODE_JOIN_NONE = 2'b10,
    MODE_JOIN_ALT  = 2'b11   // behaves exactly like MODE_JOIN
  } join_mode_e;

  typedef enum logic [1:0] {
    S_IDLE        = 2'b00,
    S_RUN_BLOCKED = 2'b01,   // parent still waiting
    S_RUN_FREE    = 2'b10    // parent released, children still running
  } fsm_state_e;

  // Parent release condition for the next edge, evaluated only while blocked.
  // any_fin : at least one child completes at the next edge
  // all_fin : the whole fork completes at the next edge (also true for an
  //           empty fork, so JOIN_ANY does not stall when nothing was launched)
  function automatic logic parent_release(input join_mode_e m,
                                          input logic       any_fin,
                                          input logic       all_fin);
    logic rel;
    case (m)
      MODE_JOIN_NONE: rel = 1'b1;
      MODE_JOIN_ANY:  rel = any_fin | all_fin;
      MODE_JOIN:      rel = all_fin;
      MODE_JOIN_ALT:  rel = all_fin;
      default:        rel = all_fin;
    endcase
    return rel;
  endfunction

endpackage

// File: rtl/task_timer.sv
// -----------------------------------------------------------------------------
// task_timer
// One child task: a down-counter loaded at fork acceptance. Active from the
// load edge until the counter runs out, then a one-cycle done pulse.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load the counter (fork accepted and this task enabled)
//   i_dur        : requested duration in cycles (0 is treated as 1)
//   o_active     : registered running flag
//   o_done       : registered one-cycle completion pulse
//   o_finishing  : combinational, task completes at the next edge
// -----------------------------------------------------------------------------
module task_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_dur,
  output logic             o_active,
  output logic             o_done,
  output logic             o_finishing
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_done;
  logic [CNT_W-1:0] w_load_val;
  logic             w_finishing;

  // Effective load value and end-of-count detect.
  always_comb begin
    if (i_dur == '0) begin
      w_load_val = CNT_ONE;
    end else begin
      w_load_val = i_dur;
    end
    w_finishing = r_active && (r_cnt == CNT_ONE);
  end

  // Counter, active flag and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= w_load_val;
      r_active <= 1'b1;
      r_done   <= 1'b0;
    end else if (w_finishing) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b1;
    end else if (r_active) begin
      r_cnt    <= r_cnt - CNT_ONE;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
    end
  end

  assign o_active    = r_active;
  assign o_done      = r_done;
  assign o_finishing = w_finishing;

endmodule

// File: rtl/fork_join_sched.sv
// -----------------------------------------------------------------------------
// fork_join_sched
// Hardware model of a fork/join: a fork launches up to NUM_TASKS timed child
// tasks; the parent is released according to the captured join mode.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : fork request (honoured only while ready)
//   mode         : 00 JOIN, 01 JOIN_ANY, 10 JOIN_NONE, 11 JOIN
//   en_mask      : tasks launched by the fork
//   dur          : per-task durations, task i in [i*CNT_W +: CNT_W]
//   ready / busy : fork acceptable / fork outstanding (ready == !busy)
//   parent_go    : one-cycle parent release pulse
//   task_active  : per-task running flags
//   task_done    : per-task completion pulses
//   all_done     : one-cycle pulse when the last task completes
// -----------------------------------------------------------------------------
module fork_join_sched
  import fork_join_pkg::*;
#(
  parameter int NUM_TASKS = DEF_NUM_TASKS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [NUM_TASKS-1:0]       en_mask,
  input  logic [NUM_TASKS*CNT_W-1:0] dur,
  output logic                       ready,
  output logic                       busy,
  output logic                       parent_go,
  output logic [NUM_TASKS-1:0]       task_active,
  output logic [NUM_TASKS-1:0]       task_done,
  output logic                       all_done
);

  fsm_state_e           r_state;
  fsm_state_e           w_state_next;
  join_mode_e           r_mode;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_parent_go;
  logic                 r_all_done;

  logic                 w_accept;
  logic [NUM_TASKS-1:0] w_active;
  logic [NUM_TASKS-1:0] w_done;
  logic [NUM_TASKS-1:0] w_finishing;
  logic [NUM_TASKS-1:0] w_remaining;
  logic                 w_go_next;
  logic                 w_all_done_next;

  assign w_accept = (r_state == S_IDLE) && start;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TASKS; gi++) begin : g_task
      task_timer #(.CNT_W(CNT_W)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept && en_mask[gi]),
        .i_dur       (dur[gi*CNT_W +: CNT_W]),
        .o_active    (w_active[gi]),
        .o_done      (w_done[gi]),
        .o_finishing (w_finishing[gi])
      );
    end
  endgenerate

  // State register and join mode captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_JOIN;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mode <= join_mode_e'(mode);
      end else begin
        r_mode <= r_mode;
      end
    end
  end

  // Next-state logic; the fork retires on the edge ending the all_done cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN_BLOCKED;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN_BLOCKED: begin
        if (r_all_done) begin
          w_state_next = S_IDLE;
        end else if (w_go_next && !w_all_done_next) begin
          w_state_next = S_RUN_FREE;
        end else begin
          w_state_next = S_RUN_BLOCKED;
        end
      end
      S_RUN_FREE: begin
        if (r_all_done) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_RUN_FREE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: next-edge values of the parent release and completion pulses.
  always_comb begin
    w_remaining = w_active & ~w_finishing;
    // Nothing left running after the next edge; r_all_done blocks a repeat
    // in the all_done cycle itself.
    if ((r_state != S_IDLE) && !r_all_done && (w_remaining == '0)) begin
      w_all_done_next = 1'b1;
    end else begin
      w_all_done_next = 1'b0;
    end
    if ((r_state == S_RUN_BLOCKED) && !r_all_done) begin
      w_go_next = parent_release(r_mode, |w_finishing, w_all_done_next);
    end else begin
      w_go_next = 1'b0;
    end
  end

  // Registered scheduler outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_parent_go <= 1'b0;
      r_all_done  <= 1'b0;
    end else begin
      r_ready     <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE);
      r_parent_go <= w_go_next;
      r_all_done  <= w_all_done_next;
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign parent_go   = r_parent_go;
  assign all_done    = r_all_done;
  assign task_active = w_active;
  assign task_done   = w_done;

endmodule

// File: tb/tb_fork_join_sched.sv
// -----------------------------------------------------------------------------
// tb_fork_join_sched
// Directed bench for fork_join_sched: each fork is launched, outputs are
// sampled on falling edges per cycle, and event cycles/counts are compared
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fork_join_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  en_mask;
  logic [31:0] dur;
  logic        ready;
  logic        busy;
  logic        parent_go;
  logic [3:0]  task_active;
  logic [3:0]  task_done;
  logic        all_done;

  int n_checks;
  int n_fail;

  // Per-run observations
  int         go_first, go_cnt, all_first, all_cnt, busy_low_first;
  int         done_first [4];
  int         done_cnt   [4];
  int         act_last   [4];
  int         ready_err;
  logic       busy0;
  logic [3:0] act_after_restart;

  fork_join_sched #(.NUM_TASKS(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .en_mask     (en_mask),
    .dur         (dur),
    .ready       (ready),
    .busy        (busy),
    .parent_go   (parent_go),
    .task_active (task_active),
    .task_done   (task_done),
    .all_done    (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Launch one fork and observe cycles 0..ncyc-1.
  // restart_cyc: cycle in which start is re-asserted (-1 none)
  // rst_cyc    : cycle in which rst is pulsed (-1 none)
  task automatic run_fork(input logic [1:0] m, input logic [3:0] msk, input logic [31:0] d,
                          input int ncyc, input int restart_cyc, input int rst_cyc);
    go_first = -1; go_cnt = 0; all_first = -1; all_cnt = 0; busy_low_first = -1;
    ready_err = 0; busy0 = 1'b0; act_after_restart = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      done_first[i] = -1; done_cnt[i] = 0; act_last[i] = -1;
    end
    @(negedge clk);
    start = 1'b1; mode = m; en_mask = msk; dur = d;
    @(posedge clk);
    #1;
    // Garbage after edge 0: only the values at the accepting edge matter.
    start = 1'b0; mode = 2'b10; en_mask = 4'b1111; dur = 32'hFFFF_FFFF;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (parent_go) begin go_cnt++; if (go_first < 0) go_first = n; end
      if (all_done)  begin all_cnt++; if (all_first < 0) all_first = n; end
      for (int i = 0; i < 4; i++) begin
        if (task_done[i]) begin done_cnt[i]++; if (done_first[i] < 0) done_first[i] = n; end
        if (task_active[i]) act_last[i] = n;
      end
      if (!busy && busy_low_first < 0) busy_low_first = n;
      if (n == 0) busy0 = busy;
      if (ready !== !busy) ready_err++;
      if (n == restart_cyc + 1) act_after_restart = task_active;
      if (n == restart_cyc) start = 1'b1;
      else start = 1'b0;
      if (n == rst_cyc) begin
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {20'd0, ready, busy, parent_go, all_done, task_active, task_done},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000});
      end
      if (n == rst_cyc + 1) rst = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; mode = 2'b00; en_mask = 4'b0000; dur = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {20'd0, ready, busy, parent_go, all_done, task_active, task_done},
          {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    rst = 1'b0;
    @(negedge clk);

    // JOIN_NONE, tasks 0/1 for 20/30 cycles
    run_fork(2'b10, 4'b0011, {8'd0, 8'd0, 8'd30, 8'd20}, 33, -1, -1);
    check("none_go_cycle", go_first, 1);
    check("none_go_count", go_cnt, 1);
    check("none_done0_cycle", done_first[0], 20);
    check("none_done1_cycle", done_first[1], 30);
    check("none_active0_last", act_last[0], 19);
    check("none_all_cycle", all_first, 30);
    check("none_all_count", all_cnt, 1);
    check("none_busy_cycle0", {31'd0, busy0}, 1);
    check("none_busy_low", busy_low_first, 31);
    check("none_task2_idle", done_cnt[2] + (act_last[2] + 1), 0);
    check("none_ready_eq_nbusy", ready_err, 0);

    // JOIN, same stimulus
    run_fork(2'b00, 4'b0011, {8'd0, 8'd0, 8'd30, 8'd20}, 33, -1, -1);
    check("join_go_cycle", go_first, 30);
    check("join_go_count", go_cnt, 1);
    check("join_all_cycle", all_first, 30);
    check("join_done0_cycle", done_first[0], 20);
    check("join_busy_low", busy_low_first, 31);

    // JOIN_ANY, 5/5/9
    run_fork(2'b01, 4'b0111, {8'd0, 8'd9, 8'd5, 8'd5}, 12, -1, -1);
    check("any_done0_cycle", done_first[0], 5);
    check("any_done1_cycle", done_first[1], 5);
    check("any_done2_cycle", done_first[2], 9);
    check("any_go_cycle", go_first, 5);
    check("any_go_count", go_cnt, 1);
    check("any_all_cycle", all_first, 9);
    check("any_task3_idle", done_cnt[3], 0);

    // Empty fork
    run_fork(2'b00, 4'b0000, 32'd0, 4, -1, -1);
    check("empty_go_cycle", go_first, 1);
    check("empty_all_cycle", all_first, 1);
    check("empty_busy_cycle0", {31'd0, busy0}, 1);
    check("empty_busy_low", busy_low_first, 2);

    // Zero-duration task beside a 4-cycle task, JOIN_ANY (mode 11 variant below)
    run_fork(2'b01, 4'b0011, {8'd0, 8'd0, 8'd4, 8'd0}, 7, -1, -1);
    check("zero_done0_cycle", done_first[0], 1);
    check("zero_go_cycle", go_first, 1);
    check("zero_all_cycle", all_first, 4);

    // Mode 11 behaves as JOIN
    run_fork(2'b11, 4'b1000, {8'd6, 8'd0, 8'd0, 8'd0}, 9, -1, -1);
    check("alt_go_cycle", go_first, 6);
    check("alt_all_cycle", all_first, 6);

    // 30-cycle fork: start re-asserted in cycle 10, reset in cycle 15
    run_fork(2'b00, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd30}, 35, 10, 15);
    check("busy_restart_ignored", {28'd0, act_after_restart}, 1);
    check("abort_no_go", go_cnt, 0);
    check("abort_no_all", all_cnt, 0);
    check("abort_no_done", done_cnt[0], 0);
    check("abort_active_last", act_last[0], 15);
    check("abort_busy_low", busy_low_first, 16);

    // New fork after reset release
    run_fork(2'b01, 4'b0011, {8'd0, 8'd0, 8'd7, 8'd3}, 10, -1, -1);
    check("post_rst_go_cycle", go_first, 3);
    check("post_rst_all_cycle", all_first, 7);
    check("post_rst_done1", done_first[1], 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
